// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/size codes, master FSM encoding and
// the command legality rule.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   // Unsupported sizes and misaligned half/word accesses never reach the bus.
   function automatic logic cmd_illegal(input logic [2:0] size, input logic [1:0] lsb);
      return (size > HSIZE_WORD) ||
             ((size == HSIZE_HALF) && lsb[0]) ||
             ((size == HSIZE_WORD) && (lsb != 2'b00));
   endfunction

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane steering: replicates write data across lanes and pulls the
// addressed lane of read data down to bit 0, zero-extended.
module ahb_lane_align
   import ahb_pkg::*;
(
   input  logic [1:0]  addr,
   input  logic [2:0]  size,
   input  logic [31:0] wdata,
   input  logic [31:0] hrdata,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   always_comb begin
      wdata_rep = wdata;
      rdata_ext = hrdata;
      case (size)
         HSIZE_BYTE: begin
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {24'd0, hrdata[{addr, 3'b000} +: 8]};
         end
         HSIZE_HALF: begin
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {16'd0, hrdata[{addr[1], 4'b0000} +: 16]};
         end
         default: begin
            wdata_rep = wdata;
            rdata_ext = hrdata;
         end
      endcase
   end

endmodule

// File: rtl/ahb_cmd_master.sv
// Single-outstanding AHB-Lite master: turns one command into one NONSEQ
// transfer and returns one response.
module ahb_cmd_master
   import ahb_pkg::*;
#(
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [2:0]  cmd_size,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   output logic [3:0]  HPROT,
   output logic        HWRITE,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [31:0] HRDATA,
   input  logic        HRESP
);

   state_e      state, state_n;
   logic [31:0] addr_q;
   logic [2:0]  size_q;
   logic        write_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        cmd_bad;
   logic [31:0] wdata_rep;
   logic [31:0] rdata_ext;

   assign cmd_bad = cmd_illegal(cmd_size, cmd_addr[1:0]);

   ahb_lane_align u_lane (
      .addr      (addr_q[1:0]),
      .size      (size_q),
      .wdata     (wdata_q),
      .hrdata    (HRDATA),
      .wdata_rep (wdata_rep),
      .rdata_ext (rdata_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   // Outputs are forced quiet while rst is high, even before state has reset.
   always_comb begin
      state_n   = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      HTRANS    = HTRANS_IDLE;
      HWDATA    = '0;
      case (state)
         ST_IDLE: begin
            cmd_ready = !rst;
            if (cmd_valid) state_n = cmd_bad ? ST_RESP : ST_ADDR;
         end
         ST_ADDR: begin
            if (!rst) HTRANS = HTRANS_NONSEQ;
            if (HREADY) state_n = ST_DATA;
         end
         ST_DATA: begin
            if (!rst) HWDATA = wdata_rep;
            if (HREADY) state_n = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = !rst;
            if (rsp_ready) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  rdata_q <= '0;
                  err_q   <= cmd_bad;
                  if (!cmd_bad) begin
                     addr_q  <= cmd_addr;
                     size_q  <= cmd_size;
                     write_q <= cmd_write;
                     wdata_q <= cmd_wdata;
                  end
               end
            end
            ST_DATA: begin
               if (HREADY) begin
                  err_q   <= HRESP;
                  rdata_q <= (HRESP || write_q) ? 32'd0 : rdata_ext;
               end
            end
            default: ;
         endcase
      end
   end

   assign HADDR     = addr_q;
   assign HSIZE     = size_q;
   assign HWRITE    = write_q;
   assign HPROT     = HPROT_VAL;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: directed scenarios plus randomized commands
// against a transaction-level reference model.
module tb_ahb_cmd_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_size;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [3:0]  HPROT;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HRESP;

   int n_checks = 0;
   int n_fail   = 0;

   ahb_cmd_master #(.HPROT_VAL(4'b0011)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_size  (cmd_size),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HSIZE     (HSIZE),
      .HPROT     (HPROT),
      .HWRITE    (HWRITE),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HRDATA    (HRDATA),
      .HRESP     (HRESP)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model, stated in plain arithmetic.
   function automatic bit m_legal(input int size, input logic [31:0] a);
      return (size == 0) || (size == 1 && a % 2 == 0) || (size == 2 && a % 4 == 0);
   endfunction

   function automatic logic [31:0] m_hwdata(input int size, input logic [31:0] w);
      if (size == 0) return (w & 32'hFF) * 32'h01010101;
      if (size == 1) return (w & 32'hFFFF) * 32'h00010001;
      return w;
   endfunction

   function automatic logic [31:0] m_rdata(input int size, input logic [31:0] a, input logic [31:0] hr);
      logic [31:0] sh;
      sh = hr >> (8 * (a % 4));
      if (size == 0) return sh & 32'hFF;
      if (size == 1) return sh & 32'hFFFF;
      return hr;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge after the response handshake.
   task automatic run_cmd(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, input int aw, input int dw,
                          input bit err, input logic [31:0] hr, input int rd);
      bit          legal;
      logic [31:0] exp_rd;
      bit          exp_err;
      legal = m_legal(int'(sz), a);
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_htrans", HTRANS, 0);
      chk("idle_hwdata", HWDATA, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
      HREADY = 1'b1; HRESP = 1'b0; rsp_ready = 1'b0;
      @(negedge clk);
      if (legal) begin
         for (int i = 0; i <= aw; i++) begin
            chk("addr_htrans", HTRANS, 2);
            chk("addr_haddr", HADDR, a);
            chk("addr_hsize", HSIZE, sz);
            chk("addr_hwrite", HWRITE, wr);
            chk("addr_hprot", HPROT, 4'b0011);
            chk("addr_hwdata", HWDATA, 0);
            chk("addr_cmd_ready", cmd_ready, 0);
            cmd_valid = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
            cmd_size = 3'($urandom); cmd_write = 1'($urandom);
            HREADY = (i == aw);
            @(negedge clk);
         end
         for (int j = 0; j <= dw; j++) begin
            chk("data_htrans", HTRANS, 0);
            chk("data_hwdata", HWDATA, m_hwdata(int'(sz), wd));
            chk("data_haddr", HADDR, a);
            chk("data_cmd_ready", cmd_ready, 0);
            chk("data_rsp_valid", rsp_valid, 0);
            HREADY = (j == dw);
            HRESP  = err && (j >= dw - 1);
            HRDATA = (j == dw) ? hr : $urandom;
            @(negedge clk);
         end
         HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
         exp_err = err;
         exp_rd  = (wr || err) ? 32'd0 : m_rdata(int'(sz), a, hr);
      end else begin
         exp_err = 1'b1;
         exp_rd  = 32'd0;
      end
      for (int k = 0; k <= rd; k++) begin
         chk("resp_valid", rsp_valid, 1);
         chk("resp_err", rsp_err, exp_err);
         chk("resp_rdata", rsp_rdata, exp_rd);
         chk("resp_cmd_ready", cmd_ready, 0);
         chk("resp_htrans", HTRANS, 0);
         chk("resp_hwdata", HWDATA, 0);
         cmd_valid = 1'($urandom); cmd_addr = $urandom; cmd_size = 3'($urandom);
         rsp_ready = (k == rd);
         @(negedge clk);
      end
      rsp_ready = 1'b0; cmd_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
      cmd_wdata = '0; rsp_ready = 1'b0; HREADY = 1'b1; HRDATA = '0; HRESP = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_htrans", HTRANS, 0);
      chk("rst_haddr", HADDR, 0);
      chk("rst_hsize", HSIZE, 0);
      chk("rst_hwrite", HWRITE, 0);
      chk("rst_hprot", HPROT, 4'b0011);
      chk("rst_hwdata", HWDATA, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", cmd_ready, 1);

      run_cmd(1'b1, 32'h40000004, 3'd2, 32'h12345678, 0, 0, 1'b0, 32'h0, 0);
      run_cmd(1'b0, 32'h40000003, 3'd0, 32'h0, 0, 3, 1'b0, 32'hAABBCCDD, 1);
      run_cmd(1'b1, 32'h40000002, 3'd1, 32'h0000BEEF, 0, 0, 1'b0, 32'h0, 0);
      run_cmd(1'b0, 32'h40000000, 3'd2, 32'h0, 0, 1, 1'b1, 32'h5A5A5A5A, 0);
      run_cmd(1'b1, 32'h40000002, 3'd2, 32'hCAFEF00D, 0, 0, 1'b0, 32'h0, 5);

      // Reset while the data phase is stalled.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40000010; cmd_size = 3'd2;
      HREADY = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("mid_addr_htrans", HTRANS, 2);
      @(negedge clk);
      HREADY = 1'b0;
      chk("mid_data_htrans", HTRANS, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_htrans", HTRANS, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 0);
      chk("mid_rst_hwdata", HWDATA, 0);
      @(negedge clk);
      chk("mid_rst_hold_cmd_ready", cmd_ready, 0);
      rst = 1'b0; HREADY = 1'b1;
      @(negedge clk);
      chk("mid_post_cmd_ready", cmd_ready, 1);
      chk("mid_post_rsp_valid", rsp_valid, 0);

      for (int t = 0; t < 80; t++) begin
         logic [31:0] a;
         logic [2:0]  sz;
         int          dw;
         bit          err;
         a  = $urandom;
         sz = 3'($urandom_range(0, 3));
         if (sz == 3'd3) sz = 3'($urandom_range(3, 7));
         if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
         dw  = $urandom_range(0, 3);
         err = ($urandom_range(0, 4) == 0);
         if (err && dw == 0) dw = 1;
         run_cmd(1'($urandom), a, sz, $urandom, $urandom_range(0, 2), dw, err,
                 $urandom, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 SHALL have parameter HPROT_VAL, default 4'b0011, the HPROT value driven on every transfer (data access, privileged).
REQ-002 SHALL have ports, clock and reset first:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  reset; synchronous, active-high.
cmd_valid  in  1  command offered.
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
cmd_write  in  1  1=write, 0=read.
cmd_addr  in  32  byte address.
cmd_size  in  3  HSIZE encoding: 0=byte, 1=half, 2=word.
cmd_wdata  in  32  write data, right-justified.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready.
rsp_rdata  out  32  read data, right-justified and zero-extended.
rsp_err  out  1  bus error or rejected command.
HADDR  out  32; HTRANS  out  2; HSIZE  out  3; HPROT  out  4; HWRITE  out  1; HWDATA  out  32.
HREADY  in  1; HRDATA  in  32; HRESP  in  1.

Function
REQ-003 SHALL issue only single NONSEQ transfers with at most one transfer outstanding; HTRANS SHALL be IDLE (2'b00) outside the address phase.
REQ-004 SHALL use FSM states IDLE, ADDR, DATA, RESP.
REQ-005 IDLE: cmd_ready=1; on handshake, latch the command and go to ADDR, or go to RESP with rsp_err=1 if the command is illegal.
REQ-006 A command is illegal when cmd_size>2, or size=1 with addr[0]!=0, or size=2 with addr[1:0]!=0; an illegal command SHALL cause no bus activity.
REQ-007 ADDR: drive HTRANS=NONSEQ, HADDR, HSIZE, HWRITE and HPROT=HPROT_VAL; hold all of these stable and stay in ADDR while HREADY=0; go to DATA on the first cycle with HREADY=1.
REQ-008 DATA: drive HWDATA with lanes replicated (byte to all 4 lanes, half to both halves, word unchanged); hold HWDATA stable; stay in DATA while HREADY=0.
REQ-009 DATA exit: on HREADY=1, capture rsp_err=HRESP and the read data, then go to RESP; HRESP=1 with HREADY=0 (first error cycle) SHALL NOT end the transfer.
REQ-010 Read data SHALL be taken from the lane selected by addr[1:0] and size, shifted to bit 0 and zero-extended; rsp_rdata SHALL be 0 on writes and on errors.
REQ-011 RESP: rsp_valid=1 and rsp_rdata/rsp_err stable until rsp_ready; on the handshake, go to IDLE.
REQ-012 Latency with zero wait states: command handshake in cycle N, address phase N+1, data phase N+2, rsp_valid in N+3; the next command may be accepted in the cycle after the response handshake.
REQ-013 cmd_ready SHALL be 0 in every state other than IDLE; commands offered then SHALL be ignored.
REQ-014 HWDATA SHALL be 0 outside DATA; HADDR/HSIZE/HWRITE MAY hold their last value while HTRANS=IDLE.

Reset
REQ-015 While rst=1: state=IDLE, HTRANS=IDLE, HADDR=0, HSIZE=0, HWRITE=0, HPROT=HPROT_VAL, HWDATA=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; cmd_ready SHALL rise in the first cycle after rst falls.
REQ-016 rst asserted mid-transfer SHALL abandon the transfer without producing a response; the bus is assumed reset together with this block.

Structure
REQ-017 Shared package ahb_pkg SHALL hold the HTRANS codes (IDLE, BUSY, NONSEQ, SEQ), the HSIZE codes (BYTE, HALF, WORD) and the FSM state encoding.
REQ-018 Lane replication and lane extraction SHALL be a combinational sub-module, ahb_lane_align; all other logic SHALL be in ahb_cmd_master.

Verification
REQ-019 Word write to 0x40000004 with data 0x12345678 and zero wait states -> NONSEQ in N+1, HWDATA=0x12345678 in N+2, rsp_valid in N+3 with rsp_err=0.
REQ-020 Byte read at 0x40000003, slave returns HRDATA=0xAABBCCDD after 3 wait states -> HADDR and HWDATA held stable throughout the wait, rsp_rdata=0x000000AA.
REQ-021 Half write at 0x40000002 with data 0x0000BEEF -> HWDATA=0xBEEFBEEF, HSIZE=1.
REQ-022 Two-cycle ERROR response (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) -> rsp_err=1, rsp_rdata=0, FSM returns to IDLE.
REQ-023 Word command at 0x40000002 -> no NONSEQ issued, rsp_err=1 in N+1; rsp_ready held low 5 cycles -> rsp_valid and rsp_err held, cmd_ready=0 throughout.
REQ-024 rst asserted while in DATA -> next cycle HTRANS=IDLE, rsp_valid=0, cmd_ready=0; cmd_ready=1 in the first cycle after rst falls.
